// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, Status/Cause field positions, ExcCode values.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int IM_BASE   = 8;
    localparam int TIMER_BIT = 15;

    localparam logic [4:0] EXC_INT = 5'd0;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0; raises a sticky pending flag when Count == Compare.
module cp0_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_wr_count,
    input  logic        i_wr_compare,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_pending
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_compare <= '0;
            r_pending <= 1'b0;
        end else begin
            r_count <= i_wr_count ? i_wr_data : r_count + 32'd1;
            if (i_wr_compare)
                r_compare <= i_wr_data;
            // Writing Compare acknowledges the timer, even on a matching cycle.
            if (i_wr_compare)
                r_pending <= 1'b0;
            else if (r_count == r_compare)
                r_pending <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_pending = r_pending;

endmodule

// File: rtl/cp0_irq.sv
// CP0 Status/Cause/EPC with interrupt arbitration and handler redirect.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_irq
    import cp0_pkg::*;
#(
    parameter int NUM_IRQ = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        wr_data,
    input  logic [4:0]         regnum,
    input  logic               MTC0,
    input  logic               ERET,
    input  logic [29:0]        next_pc,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        rd_data,
    output logic [29:0]        EPC,
    output logic               TakenInterrupt,
    output logic [2:0]         irq_id
);

    logic [NUM_IRQ-1:0] r_irq_q;
    logic [7:0]         r_im;
    logic               r_exl;
    logic               r_ie;
    logic [4:0]         r_exccode;
    logic [29:0]        r_epc;

    logic               w_timer_pending;
    logic [7:0]         w_ip;
    logic [7:0]         w_pend;
    logic               w_taken;
    logic [2:0]         w_id;

`ifdef CP0_TIMER_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;

    cp0_timer u_timer (
        .clock        (clock),
        .reset        (reset),
        .i_wr_count   (MTC0 && (regnum == CP0_COUNT)),
        .i_wr_compare (MTC0 && (regnum == CP0_COMPARE)),
        .i_wr_data    (wr_data),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_pending    (w_timer_pending)
    );
`else
    assign w_timer_pending = 1'b0;
`endif

    // External lines occupy IP[8 .. 8+NUM_IRQ-1]; IP[15] is reserved for the timer.
    always_comb begin
        w_ip                      = 8'(r_irq_q);
        w_ip[TIMER_BIT - IM_BASE] = w_timer_pending;
    end

    assign w_pend  = w_ip & r_im;
    assign w_taken = r_ie & ~r_exl & (|w_pend);

    always_comb begin
        w_id = 3'd0;
        for (int i = 0; i < 8; i++)
            if (w_pend[i])
                w_id = 3'(i);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_irq_q   <= '0;
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_irq_q <= irq;
            if (MTC0 && (regnum == CP0_STATUS)) begin
                r_im <= wr_data[IM_BASE +: 8];
                r_ie <= wr_data[ST_IE];
            end
            // An interrupt owns EXL/EPC/ExcCode on its edge; MTC0 and ERET yield.
            if (w_taken) begin
                r_exl     <= 1'b1;
                r_epc     <= next_pc;
                r_exccode <= EXC_INT;
            end else begin
                if (ERET)
                    r_exl <= 1'b0;
                else if (MTC0 && (regnum == CP0_STATUS))
                    r_exl <= wr_data[ST_EXL];
                if (MTC0 && (regnum == CP0_EPC))
                    r_epc <= wr_data[31:2];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (regnum)
            CP0_STATUS:  rd_data = {16'b0, r_im, 6'b0, r_exl, r_ie};
            CP0_CAUSE:   rd_data = {16'b0, w_ip, 1'b0, r_exccode, 2'b0};
            CP0_EPC:     rd_data = {r_epc, 2'b0};
`ifdef CP0_TIMER_EN
            CP0_COUNT:   rd_data = w_count;
            CP0_COMPARE: rd_data = w_compare;
`endif
            default:     rd_data = '0;
        endcase
    end

    assign EPC            = r_epc;
    assign TakenInterrupt = w_taken;
    assign irq_id         = w_id;

endmodule

// File: tb/tb_cp0_irq.sv
// Directed table-driven bench for cp0_irq, with hand sequences for reset and the timer.
module tb_cp0_irq;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] wr_data;
    logic [4:0]  regnum;
    logic        MTC0;
    logic        ERET;
    logic [29:0] next_pc;
    logic [6:0]  irq;
    logic [31:0] rd_data;
    logic [29:0] EPC;
    logic        TakenInterrupt;
    logic [2:0]  irq_id;

    int checks   = 0;
    int failures = 0;

    cp0_irq #(.NUM_IRQ(7)) dut (
        .clock          (clock),
        .reset          (reset),
        .wr_data        (wr_data),
        .regnum         (regnum),
        .MTC0           (MTC0),
        .ERET           (ERET),
        .next_pc        (next_pc),
        .irq            (irq),
        .rd_data        (rd_data),
        .EPC            (EPC),
        .TakenInterrupt (TakenInterrupt),
        .irq_id         (irq_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        mtc0;
        logic        eret;
        logic [4:0]  rn;
        logic [31:0] wr;
        logic [29:0] npc;
        logic [6:0]  irq;
        logic [31:0] e_rd;
        logic        e_tk;
        logic [2:0]  e_id;
        logic [29:0] e_epc;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_rd, input logic e_tk,
                              input logic [2:0] e_id, input logic [29:0] e_epc);
        chk({tag, ".rd"},    rd_data, e_rd);
        chk({tag, ".taken"}, {31'b0, TakenInterrupt}, {31'b0, e_tk});
        chk({tag, ".id"},    {29'b0, irq_id}, {29'b0, e_id});
        chk({tag, ".epc"},   {2'b0, EPC}, {2'b0, e_epc});
    endtask

    initial begin
        // Outputs are checked #1 after the negedge where inputs are driven, i.e.
        // they reflect state before the following posedge applies the vector.
        //        mtc0 eret rn  wr            npc       irq      e_rd          tk id e_epc
        vt[0]  = '{0, 0, 12, 32'h0,         30'h0,   7'h00, 32'h0,        0, 0, 30'h0};
        vt[1]  = '{0, 0, 13, 32'h0,         30'h0,   7'h00, 32'h0,        0, 0, 30'h0};
        vt[2]  = '{0, 0, 14, 32'h0,         30'h0,   7'h00, 32'h0,        0, 0, 30'h0};
        vt[3]  = '{1, 0, 12, 32'h0000_0401, 30'h0,   7'h04, 32'h0,        0, 0, 30'h0};
        vt[4]  = '{0, 0, 12, 32'h0,         30'h100, 7'h04, 32'h0000_0401, 1, 2, 30'h0};
        vt[5]  = '{0, 0, 12, 32'h0,         30'h0,   7'h04, 32'h0000_0403, 0, 2, 30'h100};
        vt[6]  = '{0, 0, 13, 32'h0,         30'h0,   7'h04, 32'h0000_0400, 0, 2, 30'h100};
        vt[7]  = '{0, 0, 14, 32'h0,         30'h0,   7'h04, 32'h0000_0400, 0, 2, 30'h100};
        vt[8]  = '{0, 1, 12, 32'h0,         30'h0,   7'h04, 32'h0000_0403, 0, 2, 30'h100};
        vt[9]  = '{1, 0, 14, 32'h0000_0208, 30'h50,  7'h04, 32'h0000_0400, 1, 2, 30'h100};
        vt[10] = '{0, 0, 14, 32'h0,         30'h0,   7'h04, 32'h0000_0140, 0, 2, 30'h50};
        vt[11] = '{1, 0, 12, 32'h0000_FF01, 30'h0,   7'h21, 32'h0000_0403, 0, 2, 30'h50};
        vt[12] = '{1, 0, 12, 32'h0000_DF01, 30'h77,  7'h21, 32'h0000_FF01, 1, 5, 30'h50};
        vt[13] = '{0, 0, 12, 32'h0,         30'h0,   7'h21, 32'h0000_DF03, 0, 0, 30'h77};
        vt[14] = '{0, 0, 13, 32'h0,         30'h0,   7'h21, 32'h0000_2100, 0, 0, 30'h77};
        vt[15] = '{1, 0, 3,  32'hFFFF_FFFF, 30'h0,   7'h00, 32'h0,        0, 0, 30'h77};
        vt[16] = '{0, 0, 12, 32'h0,         30'h0,   7'h00, 32'h0000_DF03, 0, 0, 30'h77};
        vt[17] = '{0, 1, 13, 32'h0,         30'h0,   7'h00, 32'h0,        0, 0, 30'h77};
        vt[18] = '{0, 0, 12, 32'h0,         30'h0,   7'h00, 32'h0000_DF01, 0, 0, 30'h77};

        reset = 1'b1; MTC0 = 1'b0; ERET = 1'b0; regnum = 5'd12;
        wr_data = '0; next_pc = '0; irq = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_outs("reset", 32'h0, 1'b0, 3'd0, 30'h0);
`ifdef CP0_TIMER_EN
        // Park Compare far away so the timer stays quiet during the table.
        MTC0 = 1'b1; regnum = 5'd11; wr_data = 32'hFFFF_FFFF;
`endif

        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            MTC0 = vt[i].mtc0; ERET = vt[i].eret; regnum = vt[i].rn;
            wr_data = vt[i].wr; next_pc = vt[i].npc; irq = vt[i].irq;
            #1;
            check_outs($sformatf("vec%0d", i), vt[i].e_rd, vt[i].e_tk, vt[i].e_id, vt[i].e_epc);
        end

        // Reset in mid-run clears everything, including the sampled IP bits.
        @(negedge clock);
        MTC0 = 1'b0; ERET = 1'b0; irq = 7'h7F; regnum = 5'd12; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_outs("rst2", 32'h0, 1'b0, 3'd0, 30'h0);
        @(negedge clock);
        regnum = 5'd13;
        #1;
`ifdef CP0_TIMER_EN
        chk("rst2.cause", rd_data, 32'h0000_FF00);
`else
        chk("rst2.cause", rd_data, 32'h0000_7F00);
`endif
        chk("rst2.taken", {31'b0, TakenInterrupt}, 32'h0);

`ifdef CP0_TIMER_EN
        begin
            int n;
            @(negedge clock);
            irq = '0; MTC0 = 1'b1; regnum = 5'd11; wr_data = 32'd20;
            @(negedge clock);
            regnum = 5'd9; wr_data = 32'd0;
            @(negedge clock);
            MTC0 = 1'b0;
            #1;
            chk("tmr.count_load", rd_data, 32'd0);
            n = 0;
            while (rd_data !== 32'd20 && n < 100) begin
                @(negedge clock);
                #1;
                n++;
            end
            chk("tmr.count_reach", rd_data, 32'd20);
            chk("tmr.cycles", n, 20);
            regnum = 5'd13;
            #1;
            chk("tmr.ip15_before", {31'b0, rd_data[15]}, 32'h0);
            @(negedge clock);
            #1;
            chk("tmr.ip15_set", {31'b0, rd_data[15]}, 32'h1);
            MTC0 = 1'b1; regnum = 5'd12; wr_data = 32'h0000_8001;
            @(negedge clock);
            MTC0 = 1'b0;
            #1;
            chk("tmr.id7", {29'b0, irq_id}, 32'd7);
            chk("tmr.taken", {31'b0, TakenInterrupt}, 32'h1);
            MTC0 = 1'b1; regnum = 5'd11; wr_data = 32'd100;
            @(negedge clock);
            MTC0 = 1'b0; regnum = 5'd13;
            #1;
            chk("tmr.ip15_clr", {31'b0, rd_data[15]}, 32'h0);
            chk("tmr.id_clr", {29'b0, irq_id}, 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_irq.md
# cp0_irq

Parametrised coprocessor 0 for the multicycle/pipelined MIPS datapath: holds Status, Cause and EPC, arbitrates up to seven external interrupt lines plus an optional internal count/compare timer, and tells the core when to redirect to the handler. It sits beside the register file. The core uses it for MFC0, MTC0 and ERET, and for the interrupt redirect decision on every cycle.

## Interface
Parameters:
- NUM_IRQ, 7, number of external interrupt lines; legal range 1..7; line i maps to IP/IM bit 8+i.

Ports:
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; all state is cleared on the clock edge where it is 1
- wr_data  input  32  MTC0 source operand
- regnum  input  5  CP0 register number for MFC0/MTC0
- MTC0  input  1  write wr_data to regnum this cycle
- ERET  input  1  return from exception: clear EXL
- next_pc  input  30  word address of the instruction to resume; captured into EPC
- irq  input  NUM_IRQ  level-sensitive external interrupt requests
- rd_data  output  32  combinational read of register regnum
- EPC  output  30  current EPC word address
- TakenInterrupt  output  1  redirect to handler this cycle
- irq_id  output  3  index of the highest-priority enabled pending source; 7 = timer; 0 when none

## Operation
- Status, reg 12:
  - [15:8] IM, writable.
  - [1] EXL, written by MTC0 and set/cleared by hardware.
  - [0] IE, writable.
  - Other bits read 0.
- Cause, reg 13:
  - [15:8] IP, read-only.
  - [6:2] ExcCode, read-only; written 0 on an interrupt.
  - Other bits read 0.
- EPC, reg 14: bits [31:2] are writable; [1:0] read 0. The MTC0 write uses wr_data[31:2].
- Count, reg 9, and Compare, reg 11: present only with CP0_TIMER_EN.
- Any other regnum reads 0. MTC0 to any other regnum is ignored.
- IP[8+i] is a register that samples irq[i] every cycle.
- IP[15] is timer_pending. IP bits for absent lines read 0.
- TakenInterrupt = IE & ~EXL & |(IP & IM). It is combinational from registered state only.
- irq_id is the highest set bit of (IP & IM), as bit index − 8. It is valid regardless of IE/EXL.
- On a cycle with TakenInterrupt = 1, at the clock edge:
  - EXL ← 1
  - EPC ← next_pc
  - ExcCode ← 0
- On ERET: EXL ← 0.
- Precedence for the same edge:
  - reset over everything.
  - TakenInterrupt over MTC0 for EXL, EPC and ExcCode. The other fields of the MTC0 write still apply.
  - TakenInterrupt over ERET.
- IP is never written by MTC0. A source clears only when its line drops, or when Compare is written (timer).

## Timing
- Reset value of every output and register is 0: rd_data for regnum 12/13/14, EPC, TakenInterrupt, irq_id, Count, Compare, timer_pending.
- irq rise at cycle n appears in IP, and can assert TakenInterrupt, in cycle n+1.
- After a taken interrupt, TakenInterrupt is 0 from the next cycle until ERET clears EXL.
  - EXL clears at the ERET edge.
  - An interrupt still pending is taken in the following cycle.
- MFC0 reads are zero-latency. An MTC0 value is visible to a read from the next cycle.

## Configuration
- Macro: CP0_TIMER_EN.
- Defined:
  - Count increments by 1 every cycle, wrapping 0xFFFFFFFF→0.
  - MTC0 to Count loads wr_data; the load wins over the increment that cycle.
  - When Count == Compare (registered values), timer_pending is set. It is sticky.
  - MTC0 to Compare loads the value and clears timer_pending. The clear wins over a simultaneous set.
- Undefined:
  - Regs 9/11 read 0 and ignore writes.
  - IP[15] is constant 0.
  - irq_id never reports 7.

## Structure
- Shared package cp0_pkg holds:
  - register-number constants: STATUS=12, CAUSE=13, EPC=14, COUNT=9, COMPARE=11
  - field bit positions: IE=0, EXL=1, IM/IP base 8, timer bit 15
  - the ExcCode value INT=0
- One natural sub-module, cp0_timer, which owns Count, Compare and timer_pending. It is instantiated only under CP0_TIMER_EN.
- A priority encoder is inlined.

## Test plan
- Reset, then read regs 12, 13, 14 → all 0; TakenInterrupt = 0; irq_id = 0.
- MTC0 Status = 0x0000_0401, irq[2] = 1 at cycle n:
  - cycle n+1: TakenInterrupt = 1, irq_id = 2.
  - after the edge, with next_pc = 0x100: EPC = 0x100, Status reads 0x0000_0403.
- irq[0] and irq[5] both high, IM = 0xFF, IE = 1 → irq_id = 5, TakenInterrupt = 1. Mask IM bit 13 → irq_id = 0.
- While EXL = 1, irq held high → TakenInterrupt = 0. On ERET, EXL = 0 and TakenInterrupt = 1 the next cycle.
- MTC0 EPC = 0x0000_0208 in the same cycle as TakenInterrupt with next_pc = 0x50 → EPC = 0x50, i.e. the interrupt wins.
- With CP0_TIMER_EN:
  - Compare = 20, Count = 0 → IP[15] sets when Count reaches 20. Status = 0x8001 → irq_id = 7.
  - Write Compare = 100 → IP[15] clears the next cycle.
